// File: rtl/contador_sched.sv
// Round-robin job scheduler that drives an external up/down counter.
// Two requesters post jobs (mode, preset, run length); the winner is loaded, run, and reported.
module contador_sched #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       mode0,
    input  logic [1:0]       mode1,
    input  logic [3:0]       d0,
    input  logic [3:0]       d1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             wrap,
    output logic             busy,
    output logic             cnt_enable,
    output logic [1:0]       cnt_mode,
    output logic [3:0]       cnt_D,
    input  logic             cnt_rco
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             arm_q, arm_d;
    logic             prio_q, prio_d;
    logic             who_q, who_d;
    logic [1:0]       job_mode_q, job_mode_d;
    logic [3:0]       job_pre_q, job_pre_d;
    logic [LEN_W-1:0] job_len_q, job_len_d;
    logic [LEN_W-1:0] run_q, run_d;
    logic             wrap_q, wrap_d;
    logic             win_s;

    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             busy_q, busy_d;
    logic             cnt_enable_q, cnt_enable_d;
    logic [1:0]       cnt_mode_q, cnt_mode_d;
    logic [3:0]       cnt_D_q, cnt_D_d;

    // Next-state, arbitration and job capture
    always_comb begin
        state_d    = state_q;
        arm_d      = 1'b1;
        prio_d     = prio_q;
        who_d      = who_q;
        job_mode_d = job_mode_q;
        job_pre_d  = job_pre_q;
        job_len_d  = job_len_q;
        run_d      = run_q;
        wrap_d     = wrap_q;

        // prio_q names the requester that wins a tie (the one not served last)
        if (req0 && req1) begin
            win_s = prio_q;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // arm_q holds off the first grant until one edge after reset release
                if (arm_q && (req0 || req1)) begin
                    state_d    = S_LOAD;
                    who_d      = win_s;
                    prio_d     = ~win_s;
                    job_mode_d = win_s ? mode1 : mode0;
                    job_pre_d  = win_s ? d1 : d0;
                    job_len_d  = win_s ? len1 : len0;
                    run_d      = '0;
                    wrap_d     = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if ((job_len_q != '0) && (job_mode_q != 2'b11)) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_RUN: begin
                run_d  = run_q + LEN_W'(1);
                wrap_d = wrap_q | cnt_rco;
                if (run_d == job_len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the cycle being entered, so every output comes straight from a flop
    always_comb begin
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        busy_d       = 1'b1;
        cnt_enable_d = 1'b0;
        cnt_mode_d   = 2'b00;
        cnt_D_d      = cnt_D_q;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_LOAD: begin
                gnt0_d       = ~who_d;
                gnt1_d       = who_d;
                cnt_enable_d = 1'b1;
                cnt_mode_d   = 2'b11;
                cnt_D_d      = job_pre_d;
            end
            S_RUN: begin
                cnt_enable_d = 1'b1;
                cnt_mode_d   = job_mode_d;
                cnt_D_d      = job_pre_d;
            end
            S_DONE: begin
                done0_d = ~who_d;
                done1_d = who_d;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, job and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            arm_q        <= 1'b0;
            prio_q       <= 1'b0;
            who_q        <= 1'b0;
            job_mode_q   <= 2'b00;
            job_pre_q    <= 4'b0000;
            job_len_q    <= '0;
            run_q        <= '0;
            wrap_q       <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            busy_q       <= 1'b0;
            cnt_enable_q <= 1'b0;
            cnt_mode_q   <= 2'b00;
            cnt_D_q      <= 4'b0000;
        end else begin
            state_q      <= state_d;
            arm_q        <= arm_d;
            prio_q       <= prio_d;
            who_q        <= who_d;
            job_mode_q   <= job_mode_d;
            job_pre_q    <= job_pre_d;
            job_len_q    <= job_len_d;
            run_q        <= run_d;
            wrap_q       <= wrap_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            busy_q       <= busy_d;
            cnt_enable_q <= cnt_enable_d;
            cnt_mode_q   <= cnt_mode_d;
            cnt_D_q      <= cnt_D_d;
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign wrap       = wrap_q;
    assign busy       = busy_q;
    assign cnt_enable = cnt_enable_q;
    assign cnt_mode   = cnt_mode_q;
    assign cnt_D      = cnt_D_q;

endmodule

// File: doc/contador_sched.md
CONTADOR_SCHED -- requirements
Module: contador_sched

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the per-job run-length fields and the run counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports req0, req1  input  1  job request from requester 0 or 1; held high until the matching grant.
REQ-005 SHALL have ports mode0, mode1  input  2  counting mode for the job.
REQ-006 SHALL have ports d0, d1  input  4  preset value for the job.
REQ-007 SHALL have ports len0, len1  input  LEN_W  number of RUN cycles.
REQ-008 SHALL have ports gnt0, gnt1  output  1  one-cycle grant pulse; job fields have been captured.
REQ-009 SHALL have ports done0, done1  output  1  one-cycle job-complete pulse.
REQ-010 SHALL have port wrap  output  1  cnt_rco was seen during the job; valid while done0 or done1 is high.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port cnt_enable  output  1  drives the counter enable.
REQ-013 SHALL have port cnt_mode  output  2  drives the counter mode.
REQ-014 SHALL have port cnt_D  output  4  drives the counter preset.
REQ-015 SHALL have port cnt_rco  input  1  counter ripple-carry-out.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, LOAD, RUN, DONE; all outputs are registered or decoded from state and registers only.
REQ-017 Counter mode encoding SHALL be: 00 up by 1, 01 down by 1, 10 down by 3, 11 load D.
REQ-018 In IDLE with at least one req high, the FSM SHALL move to LOAD at the next edge.
REQ-019 On that edge it SHALL capture the winner's mode, d and len into job registers.
REQ-020 Arbitration SHALL be round-robin: with only one req high, that requester wins; with both high, the requester not served last wins.
REQ-021 After reset, requester 0 SHALL be treated as "not served last" and so wins the first tie.
REQ-022 In LOAD, gnt of the winner SHALL be 1 for exactly that cycle, with cnt_enable=1, cnt_mode=11 and cnt_D=captured d.
REQ-023 LOAD SHALL last one cycle; it goes to RUN if captured len!=0 and captured mode!=11, otherwise to DONE.
REQ-024 In RUN: cnt_enable=1, cnt_mode=captured mode, cnt_D=captured d; the run counter increments each cycle.
REQ-025 RUN SHALL exit to DONE after exactly len cycles (len in 1..2^LEN_W-1).
REQ-026 In DONE: cnt_enable=0; done of the served requester=1 for one cycle; the FSM returns to IDLE next edge.
REQ-027 Outside LOAD and RUN, cnt_enable=0 and cnt_mode=00; cnt_D holds its last value.
REQ-028 The wrap register SHALL clear in LOAD and set (sticky) if cnt_rco=1 is sampled on any RUN cycle.
REQ-029 Job latency: req high in IDLE at cycle t gives gnt at t+1, RUN at t+2..t+1+len, and done at t+2+len.
REQ-030 Minimum gap between jobs SHALL be one IDLE cycle after DONE; no new grant is issued in DONE.
REQ-031 Request inputs SHALL be ignored outside IDLE.
REQ-032 A req dropped before its grant SHALL have no effect.
REQ-033 Changes to job inputs after the grant SHALL not affect the running job.

Reset
REQ-034 While reset=0, asynchronously: state=IDLE, all gnt, done, busy, wrap, cnt_enable=0, cnt_mode=00, cnt_D=0000, job and run registers=0, RR pointer to requester 0.
REQ-035 Reset during LOAD, RUN or DONE SHALL abort the job with no done pulse.
REQ-036 The first grant after reset release SHALL occur no earlier than the second rising edge after release.

Verification
REQ-037 Scenario: req0=1, mode0=00, d0=5, len0=3 -> gnt0 at t+1 with cnt_mode=11, cnt_D=5; cnt_enable=1 for cycles t+1..t+4; done0 at t+5; wrap=0.
REQ-038 Scenario: req0 and req1 both high continuously -> grants alternate 0,1,0,1, with each job completing before the next gnt.
REQ-039 Scenario: len1=0, or mode1=11 -> LOAD then DONE; done1 at t+2; no RUN cycles.
REQ-040 Scenario: cnt_rco forced high for one RUN cycle -> wrap=1 at the done pulse; the next job's wrap=0.
REQ-041 Scenario: reset asserted mid-RUN -> cnt_enable=0 immediately; no done pulse; after release, req1 and req0 together give gnt0 first.
